branch_trace_sequencer: RTL and testbench

BRANCH_TRACE_SEQUENCER -- requirements
Module: branch_trace_sequencer

---
 rtl/branch_trace_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_branch_trace_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_trace_sequencer
// Description : Queues branch trace records and replays them one at a time
//               into a branch predictor, collecting prediction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_trace_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rec_valid,
    input  logic [ADDR_WIDTH-1:0] rec_addr,
    input  logic                  rec_taken,
    output logic                  rec_ready,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  new_data_avail,
    output logic                  direction_ground_truth,
    input  logic                  mem_reset_done,
    input  logic                  pred_ready,
    input  logic                  prediction,
    input  logic                  training_done,
    input  logic                  clear_stats,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    output logic                  last_prediction,
    output logic                  last_mispredict,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_OCC_W-1:0]   c_OCC_FULL = c_OCC_W'(FIFO_DEPTH);
    localparam logic [c_OCC_W-1:0]   c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_TMR_W-1:0]   c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [2:0] c_INIT      = 3'd0;
    localparam logic [2:0] c_IDLE      = 3'd1;
    localparam logic [2:0] c_ISSUE     = 3'd2;
    localparam logic [2:0] c_WAIT_PRED = 3'd3;
    localparam logic [2:0] c_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_GAP       = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_mem_addr  [FIFO_DEPTH];
    logic                  r_mem_taken [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_count;
    logic [ADDR_WIDTH-1:0] r_inst_addr;
    logic                  r_truth;
    logic                  r_nda;
    logic [c_TMR_W-1:0]    r_timer;
    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispred_cnt;
    logic                  r_last_pred;
    logic                  r_last_mispred;
    logic                  r_timeout_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_waiting;
    logic w_capture;
    logic w_retire;
    logic w_timeout;
    logic w_pop;
    logic w_issue;
    logic w_mispred;

    // Readiness follows registered occupancy only, so a pop never frees a slot
    // in the same cycle; rst_n gating holds it low while reset is asserted.
    assign w_full    = (r_count == c_OCC_FULL);
    assign w_empty   = (r_count == '0);
    assign rec_ready = rst_n & ~w_full;
    assign w_push    = rec_valid & rec_ready;

    assign w_waiting = (r_state == c_WAIT_PRED) || (r_state == c_WAIT_DONE);
    assign w_capture = (r_state == c_WAIT_PRED) && pred_ready;
    assign w_retire  = ((r_state == c_WAIT_PRED) && pred_ready && training_done)
                    || ((r_state == c_WAIT_DONE) && training_done);
    assign w_timeout = w_waiting && (r_timer == c_TMR_LAST) && !w_retire;
    assign w_pop     = w_retire || w_timeout;
    assign w_issue   = ((r_state == c_IDLE) || (r_state == c_GAP)) && !w_empty;
    assign w_mispred = (prediction != r_truth);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= rec_addr;
            r_mem_taken[r_wr_ptr] <= rec_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + c_OCC_ONE;
            else if (!w_push && w_pop) r_count <= r_count - c_OCC_ONE;
        end
    end

    // GAP holds new_data_avail low for one cycle; when another record is
    // already queued it is loaded right there so the low pulse stays one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_INIT;
            r_inst_addr <= '0;
            r_truth     <= 1'b0;
            r_nda       <= 1'b0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                c_INIT: begin
                    if (mem_reset_done) r_state <= c_IDLE;
                end
                c_IDLE, c_GAP: begin
                    if (w_issue) begin
                        r_state     <= c_ISSUE;
                        r_inst_addr <= r_mem_addr[r_rd_ptr];
                        r_truth     <= r_mem_taken[r_rd_ptr];
                        r_nda       <= 1'b1;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_ISSUE: begin
                    r_state <= c_WAIT_PRED;
                    r_timer <= '0;
                end
                c_WAIT_PRED, c_WAIT_DONE: begin
                    r_timer <= r_timer + c_TMR_ONE;
                    if (w_pop) begin
                        r_state <= c_GAP;
                        r_nda   <= 1'b0;
                    end else if (w_capture) begin
                        r_state <= c_WAIT_DONE;
                    end
                end
                default: begin
                    r_state <= c_INIT;
                    r_nda   <= 1'b0;
                end
            endcase
        end
    end

    // A clear in the same cycle as an increment wins; last_* are not stats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt   <= '0;
            r_mispred_cnt  <= '0;
            r_timeout_err  <= 1'b0;
            r_last_pred    <= 1'b0;
            r_last_mispred <= 1'b0;
        end else begin
            if (clear_stats) begin
                r_branch_cnt  <= '0;
                r_mispred_cnt <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_retire && (r_branch_cnt != c_CNT_MAX))
                    r_branch_cnt <= r_branch_cnt + c_CNT_ONE;
                if (w_capture && w_mispred && (r_mispred_cnt != c_CNT_MAX))
                    r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
                if (w_timeout)
                    r_timeout_err <= 1'b1;
            end
            if (w_capture) begin
                r_last_pred    <= prediction;
                r_last_mispred <= w_mispred;
            end
        end
    end

    assign inst_addr              = r_inst_addr;
    assign direction_ground_truth = r_truth;
    assign new_data_avail         = r_nda;
    assign branch_count           = r_branch_cnt;
    assign mispredict_count       = r_mispred_cnt;
    assign last_prediction        = r_last_pred;
    assign last_mispredict        = r_last_mispred;
    assign timeout_err            = r_timeout_err;
    assign busy = (r_state == c_ISSUE) || w_waiting || (r_state == c_GAP) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_branch_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_trace_sequencer
// Description : Self-checking bench; the bench acts as the predictor and keeps
//               a queue-based reference of records and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_trace_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int TMO   = 64;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int NV    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rec_valid = 1'b0;
    logic [AW-1:0] rec_addr = '0;
    logic          rec_taken = 1'b0;
    logic          rec_ready;
    logic [AW-1:0] inst_addr;
    logic          new_data_avail;
    logic          direction_ground_truth;
    logic          mem_reset_done = 1'b0;
    logic          pred_ready = 1'b0;
    logic          prediction = 1'b0;
    logic          training_done = 1'b0;
    logic          clear_stats = 1'b0;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;
    logic          last_prediction;
    logic          last_mispredict;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    branch_trace_sequencer #(
        .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rec_valid(rec_valid), .rec_addr(rec_addr), .rec_taken(rec_taken), .rec_ready(rec_ready),
        .inst_addr(inst_addr), .new_data_avail(new_data_avail),
        .direction_ground_truth(direction_ground_truth),
        .mem_reset_done(mem_reset_done), .pred_ready(pred_ready), .prediction(prediction),
        .training_done(training_done), .clear_stats(clear_stats),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .last_prediction(last_prediction), .last_mispredict(last_mispredict),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            taken;
        bit            pred;
        int            pd;
        int            dd;
        bit            noise;
        bit            never;
        bit            clr;
        int            exp_bc;
        int            exp_mc;
        bit            exp_terr;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            taken;
    } rec_t;

    rec_t m_q[$];
    int   m_bc = 0;
    int   m_mc = 0;
    bit   m_terr = 1'b0;
    bit   m_lp = 1'b0;
    bit   m_lm = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   nda_hi = 0;
    vec_t tbl[NV];

    // Length of the current new_data_avail high run, sampled before the edge updates it.
    always @(posedge clk) begin
        if (new_data_avail) nda_hi <= nda_hi + 1;
        else                nda_hi <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input bit pred, input int pd, input int dd);
        vec_t v;
        v = '{8'h00, 1'b0, pred, pd, dd, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bc = 0; m_mc = 0; m_terr = 1'b0; m_lp = 1'b0; m_lm = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input bit t);
        rec_t r;
        chk("push_ready", rec_ready, (m_q.size() < DEPTH));
        rec_valid = 1'b1; rec_addr = a; rec_taken = t;
        tick();
        rec_valid = 1'b0;
        if (m_q.size() < DEPTH) begin
            r.addr = a; r.taken = t;
            m_q.push_back(r);
        end
    endtask

    task automatic do_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        m_bc = 0; m_mc = 0; m_terr = 1'b0;
        chk("clear_bc", branch_count, 0);
        chk("clear_terr", timeout_err, 0);
    endtask

    // Plays the predictor for the record at the head of the model queue.
    task automatic serve(input vec_t v);
        int            n;
        logic [AW-1:0] a_exp;
        bit            t_exp;
        rec_t          dropped;
        n = 0;
        while (!new_data_avail && n < 400) begin
            tick();
            n++;
        end
        chk("issue_seen", new_data_avail, 1);
        if (!new_data_avail || m_q.size() == 0) return;
        a_exp = m_q[0].addr;
        t_exp = m_q[0].taken;
        chk("inst_addr", inst_addr, a_exp);
        chk("dir_truth", direction_ground_truth, t_exp);
        if (v.never) begin
            n = 0;
            while (new_data_avail && n < 200) begin
                tick();
                n++;
            end
            chk("timeout_len", nda_hi, TMO + 1);
            dropped = m_q.pop_front();
            m_terr = 1'b1;
        end else begin
            for (int k = 1; k <= v.dd; k++) begin
                tick();
                if (k == v.dd) begin
                    chk("nda_held", new_data_avail, 1);
                    chk("addr_held", inst_addr, a_exp);
                end
                pred_ready    = (k == v.pd) || (v.noise && k == v.dd - 1 && k > v.pd);
                prediction    = (k == v.pd) ? v.pred : !v.pred;
                training_done = (k == v.dd) || (v.noise && k == v.pd - 1);
                clear_stats   = v.clr && (k == v.dd);
            end
            tick();
            pred_ready = 1'b0; training_done = 1'b0; clear_stats = 1'b0; prediction = 1'b0;
            dropped = m_q.pop_front();
            m_lp = v.pred;
            m_lm = (v.pred != t_exp);
            if (v.clr) begin
                m_bc = 0; m_mc = 0; m_terr = 1'b0;
            end else begin
                if (m_bc < CMAX) m_bc++;
                if (m_lm && m_mc < CMAX) m_mc++;
            end
        end
        chk("nda_gap", new_data_avail, 0);
        chk("busy_gap", busy, 1);
        chk("branch_count", branch_count, m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
        chk("timeout_err", timeout_err, m_terr);
        chk("last_prediction", last_prediction, m_lp);
        chk("last_mispredict", last_mispredict, m_lm);
        chk("ready_after_pop", rec_ready, (m_q.size() < DEPTH));
        if (m_q.size() > 0) begin
            tick();
            chk("gap_one_cycle", new_data_avail, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rec_t r5;
        int   pushed;
        bit   seen;

        tbl[0] = '{8'h10, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0};
        tbl[1] = '{8'h21, 1'b0, 1'b1, 3, 7, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0};
        tbl[2] = '{8'h32, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0};
        tbl[3] = '{8'h43, 1'b0, 1'b0, 5, 9, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0};
        tbl[4] = '{8'h54, 1'b1, 1'b1, 1, 4, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
        tbl[5] = '{8'h65, 1'b1, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1};
        tbl[6] = '{8'h76, 1'b0, 1'b1, 4, 6, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1};
        tbl[7] = '{8'h87, 1'b1, 1'b1, 2, 3, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0};

        // Reset values while held in reset
        tick(); tick();
        chk("rst_rec_ready", rec_ready, 0);
        chk("rst_nda", new_data_avail, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inst_addr", inst_addr, 0);
        chk("rst_counts", {branch_count, mispredict_count}, 0);
        chk("rst_flags", {last_prediction, last_mispredict, timeout_err, direction_ground_truth}, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_rec_ready", rec_ready, 1);

        // Records pushed during INIT wait for mem_reset_done
        push(8'h44, 1'b1);
        push(8'h45, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (new_data_avail) seen = 1'b1;
        end
        chk("no_issue_in_init", seen, 0);
        chk("busy_init_queued", busy, 1);
        mem_reset_done = 1'b1;
        tick();
        mem_reset_done = 1'b0;
        serve(mk(1'b0, 10, 50));
        chk("first_mispredict", {branch_count, mispredict_count, last_mispredict}, {4'd1, 4'd1, 1'b1});
        serve(mk(1'b0, 1, 1));
        tick();
        chk("idle_not_busy", busy, 0);

        // Backpressure: fifth record waits for the first retire, all in order
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i), 1'(i));
        rec_valid = 1'b1; rec_addr = 8'hE4; rec_taken = 1'b1;
        tick();
        chk("full_not_ready", rec_ready, 0);
        serve(mk(1'b1, 2, 5));
        rec_valid = 1'b0;
        r5.addr = 8'hE4; r5.taken = 1'b1;
        m_q.push_back(r5);
        chk("refull_not_ready", rec_ready, 0);
        while (m_q.size() > 0) serve(mk(1'b1, 1, 2));
        tick();

        // Table-driven records
        do_clear();
        pushed = 0;
        for (int i = 0; i < NV; i++) begin
            while (pushed < NV && pushed <= i + 1 && m_q.size() < DEPTH) begin
                push(tbl[pushed].addr, tbl[pushed].taken);
                pushed++;
            end
            serve(tbl[i]);
            chk("tbl_bc", branch_count, tbl[i].exp_bc);
            chk("tbl_mc", mispredict_count, tbl[i].exp_mc);
            chk("tbl_terr", timeout_err, tbl[i].exp_terr);
        end
        tick();

        // Saturation of both counters
        do_clear();
        for (int i = 0; i < 18; i++) begin
            push(8'(i), 1'b1);
            serve(mk(1'b0, 1, 2));
        end
        chk("sat_bc", branch_count, CMAX);
        chk("sat_mc", mispredict_count, CMAX);

        // Randomized records against the reference model
        for (int r = 0; r < 40; r++) begin
            int np;
            np = $urandom_range(1, 2);
            for (int j = 0; j < np; j++)
                if (m_q.size() < DEPTH) push(8'($urandom), 1'($urandom_range(0, 1)));
            v.addr  = '0;
            v.taken = 1'b0;
            v.pred  = 1'($urandom_range(0, 1));
            v.pd    = $urandom_range(1, 12);
            v.dd    = ($urandom_range(0, 3) == 0) ? v.pd : v.pd + $urandom_range(1, 15);
            v.noise = 1'($urandom_range(0, 1));
            v.never = ($urandom_range(0, 15) == 0);
            v.clr   = ($urandom_range(0, 9) == 0);
            serve(v);
        end
        while (m_q.size() > 0) serve(mk(1'b1, 1, 1));
        tick();
        chk("drained_idle", busy, 0);

        // Reset in WAIT_DONE with three records queued
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 50 && !new_data_avail; i++) tick();
        tick();
        pred_ready = 1'b1; prediction = 1'b1;
        tick();
        pred_ready = 1'b0; prediction = 1'b0;
        tick();
        chk("pre_reset_nda", new_data_avail, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_nda", new_data_avail, 0);
        chk("ar_inst_addr", inst_addr, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rec_ready", rec_ready, 0);
        chk("ar_counts", {branch_count, mispredict_count}, 0);
        chk("ar_flags", {last_prediction, last_mispredict, timeout_err, direction_ground_truth}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("ar_rel_ready", rec_ready, 1);
        chk("ar_rel_empty", busy, 0);
        push(8'h5A, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (new_data_avail) seen = 1'b1;
        end
        chk("ar_no_issue", seen, 0);
        mem_reset_done = 1'b1;
        tick();
        mem_reset_done = 1'b0;
        serve(mk(1'b0, 2, 3));
        tick();
        chk("ar_final_bc", branch_count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
